ma_writeback_buffer: RTL and testbench
======================================

# ma_writeback_buffer

Result buffer between the MA unit output and the register-file write arbiter. It captures every valid MA result (data, destination index, issue number) into an in-order FIFO. It requests the write port and releases one entry per granted cycle. It raises a stall toward the issue stage early enough to absorb results still in flight in the MA pipeline.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥ 4
- STALL_TH, 4, occupancy at which O_Stall asserts; covers DEPTH_MLT + DEPTH_ADD in-flight results; 1 ≤ STALL_TH ≤ DEPTH
- WIDTH_DATA, 32, result data width (data_t)
- WIDTH_INDEX, 8, destination register index width (index_t)
- WIDTH_ISSUE, 7, issue number width (issue_no_t)

Ports:
- clock  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- I_Flush  in  1  synchronous clear of all entries
- I_Valid  in  1  MA result valid this cycle
- I_Data  in  WIDTH_DATA  MA result data
- I_Index  in  WIDTH_INDEX  destination register index
- I_Issue_No  in  WIDTH_ISSUE  issue number of the result
- I_Grant  in  1  write port granted to this buffer this cycle
- O_Req  out  1  write-port request; high while buffer non-empty
- O_Data  out  WIDTH_DATA  head-entry data
- O_Index  out  WIDTH_INDEX  head-entry index
- O_Issue_No  out  WIDTH_ISSUE  head-entry issue number
- O_Count  out  log2(DEPTH)+1  current occupancy
- O_Stall  out  1  back-pressure to issue stage
- O_Overflow  out  1  sticky error: result dropped on full

## Operation
- Storage: DEPTH-entry circular buffer {data, index, issue_no}. Write pointer and read pointer are each log2(DEPTH) bits and wrap modulo DEPTH. Count register has log2(DEPTH)+1 bits.
- Push: I_Valid=1 and (count < DEPTH, or a pop occurs in the same cycle). The entry is written at wr_ptr, and wr_ptr increments.
- Pop: O_Req & I_Grant. rd_ptr increments.
- Count update: count += push − pop. A simultaneous push and pop leaves count unchanged, including when count = DEPTH (full) and when count = 1.
- Push on an empty buffer does not bypass to the output. Data is always presented from storage.
- Full with I_Valid=1 and no pop: the result is dropped, and O_Overflow sets and remains set until reset. A normal flush does not clear O_Overflow. This case is a design error, because O_Stall is meant to prevent it.
- I_Grant with O_Req=0 is ignored: no pointer movement.
- O_Req = (count ≠ 0). O_Data, O_Index and O_Issue_No = mem[rd_ptr]. These are don't-care when O_Req=0 but must be stable, with no X, after reset.
- O_Stall = (count ≥ STALL_TH), combinational from the count register.
- I_Flush: next cycle, count=0 and both pointers=0. Flush has priority over a push and a pop in the same cycle; both are discarded.
- Ordering: entries leave strictly in arrival order. The issue-number sequence at O_Issue_No equals the accepted I_Issue_No sequence.

## Timing
- Reset (reset=0, asynchronous): count=0, pointers=0, O_Req=0, O_Stall=0, O_Overflow=0, O_Count=0. O_Data, O_Index and O_Issue_No read 0, because storage is cleared at reset.
- Latency: a push in cycle N appears at the outputs, with O_Req=1, in cycle N+1 when the buffer was empty.
- Throughput: one push and one pop per cycle sustained.
- Reset asserted mid-operation: all state clears immediately; no partial write survives.
- O_Stall rises in the cycle after the push that makes count reach STALL_TH. It falls in the cycle after the pop that makes count < STALL_TH.

## Test plan
- Reset then single push (Data=0x0000_00A5, Index=3, Issue=5) -> O_Req=1 next cycle with the same values. Grant 1 cycle -> O_Req=0, O_Count=0.
- Push 4 results with Issue 10..13, no grant -> O_Count=4 and O_Stall=1 after the 4th. Grant 4 cycles -> outputs issue 10,11,12,13 in order, and O_Stall=0 after count=3.
- Fill to 8 with no grant, then push and grant in the same cycle -> count stays 8, O_Overflow=0, head advances by one.
- Fill to 8, push with no grant -> O_Overflow=1 sticky, count=8, the dropped value never appears.
- Count=5, assert I_Flush together with I_Valid and I_Grant -> next cycle count=0, O_Req=0, O_Stall=0.
- Continuous push and grant for 20 cycles (issue 0..19) -> pointers wrap twice, output sequence 0..19 one cycle delayed, count constant at 1. Assert reset at cycle 12 -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ma_writeback_buffer_if.sv
// Handshake bundle between the MA result path, the write-port arbiter and the writeback buffer.
interface ma_writeback_buffer_if #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned WIDTH_DATA  = 32,
    parameter int unsigned WIDTH_INDEX = 8,
    parameter int unsigned WIDTH_ISSUE = 7
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                   I_Flush;
    logic                   I_Valid;
    logic [WIDTH_DATA-1:0]  I_Data;
    logic [WIDTH_INDEX-1:0] I_Index;
    logic [WIDTH_ISSUE-1:0] I_Issue_No;
    logic                   I_Grant;
    logic                   O_Req;
    logic [WIDTH_DATA-1:0]  O_Data;
    logic [WIDTH_INDEX-1:0] O_Index;
    logic [WIDTH_ISSUE-1:0] O_Issue_No;
    logic [CNT_W-1:0]       O_Count;
    logic                   O_Stall;
    logic                   O_Overflow;

    modport master (
        output I_Flush, I_Valid, I_Data, I_Index, I_Issue_No, I_Grant,
        input  O_Req, O_Data, O_Index, O_Issue_No, O_Count, O_Stall, O_Overflow
    );

    modport slave (
        input  I_Flush, I_Valid, I_Data, I_Index, I_Issue_No, I_Grant,
        output O_Req, O_Data, O_Index, O_Issue_No, O_Count, O_Stall, O_Overflow
    );
endinterface

// File: rtl/ma_writeback_buffer.sv
// In-order result FIFO between the MA unit and the register-file write arbiter,
// with early stall toward issue and a sticky overflow flag.
module ma_writeback_buffer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned STALL_TH    = 4,
    parameter int unsigned WIDTH_DATA  = 32,
    parameter int unsigned WIDTH_INDEX = 8,
    parameter int unsigned WIDTH_ISSUE = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    ma_writeback_buffer_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [WIDTH_DATA-1:0]  data;
        logic [WIDTH_INDEX-1:0] index;
        logic [WIDTH_ISSUE-1:0] issue_no;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_req;
    logic             r_stall;
    logic             r_overflow;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [CNT_W-1:0] w_count_nxt;
    entry_t           w_wr_entry;

    // A full buffer still accepts a result when the head leaves in the same cycle.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = r_req & bus.I_Grant;
    assign w_push  = bus.I_Valid & (~w_full | w_pop);
    assign w_drop  = bus.I_Valid & w_full & ~w_pop & ~bus.I_Flush;

    assign w_count_nxt = bus.I_Flush ? '0
                       : CNT_W'(r_count + CNT_W'(w_push) - CNT_W'(w_pop));

    assign w_wr_entry = '{data: bus.I_Data, index: bus.I_Index, issue_no: bus.I_Issue_No};

    // Pointers, occupancy and the flags derived from next occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_req      <= 1'b0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_req   <= (w_count_nxt != '0);
            r_stall <= (w_count_nxt >= CNT_W'(STALL_TH));
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (bus.I_Flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
                end
                if (w_pop) begin
                    r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
                end
            end
        end
    end

    // Storage is cleared at reset so the head outputs never show X.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !bus.I_Flush) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    assign bus.O_Req      = r_req;
    assign bus.O_Data     = r_mem[r_rd_ptr].data;
    assign bus.O_Index    = r_mem[r_rd_ptr].index;
    assign bus.O_Issue_No = r_mem[r_rd_ptr].issue_no;
    assign bus.O_Count    = r_count;
    assign bus.O_Stall    = r_stall;
    assign bus.O_Overflow = r_overflow;

endmodule

// File: tb/tb_ma_writeback_buffer.sv
// Self-checking bench for ma_writeback_buffer: queue-based reference model plus directed literal checks.
module tb_ma_writeback_buffer;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned STALL_TH = 4;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  index;
        logic [6:0]  issue;
    } ent_t;

    logic clock;
    logic reset;
    bit   chk_en;
    int   n_checks;
    int   n_errors;

    ent_t m_q[$];
    bit   m_ovf;

    ma_writeback_buffer_if #(.DEPTH(DEPTH), .WIDTH_DATA(32), .WIDTH_INDEX(8), .WIDTH_ISSUE(7)) bus ();

    ma_writeback_buffer #(
        .DEPTH(DEPTH), .STALL_TH(STALL_TH),
        .WIDTH_DATA(32), .WIDTH_INDEX(8), .WIDTH_ISSUE(7)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: queue of accepted results; head leaves before the new one joins.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else if (bus.I_Flush) begin
            m_q.delete();
        end else begin
            bit popped;
            bit was_full;
            ent_t e;
            popped   = (m_q.size() != 0) && bus.I_Grant;
            was_full = (m_q.size() == int'(DEPTH));
            if (popped) void'(m_q.pop_front());
            if (bus.I_Valid) begin
                if (!was_full || popped) begin
                    e.data  = bus.I_Data;
                    e.index = bus.I_Index;
                    e.issue = bus.I_Issue_No;
                    m_q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("count", 32'(bus.O_Count), 32'(m_q.size()));
            check("req", 32'(bus.O_Req), 32'(m_q.size() != 0));
            check("stall", 32'(bus.O_Stall), 32'(m_q.size() >= int'(STALL_TH)));
            check("overflow", 32'(bus.O_Overflow), 32'(m_ovf));
            if (m_q.size() != 0) begin
                check("data", bus.O_Data, m_q[0].data);
                check("index", 32'(bus.O_Index), 32'(m_q[0].index));
                check("issue", 32'(bus.O_Issue_No), 32'(m_q[0].issue));
            end
        end
    end

    // Drive one cycle of inputs, then return just after the active edge.
    task automatic tick(input bit v, input logic [31:0] d, input logic [7:0] idx,
                        input logic [6:0] iss, input bit g, input bit f);
        @(negedge clock);
        #1;
        bus.I_Valid    = v;
        bus.I_Data     = d;
        bus.I_Index    = idx;
        bus.I_Issue_No = iss;
        bus.I_Grant    = g;
        bus.I_Flush    = f;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        reset = 1'b0;
        bus.I_Valid = 1'b0; bus.I_Grant = 1'b0; bus.I_Flush = 1'b0;
        bus.I_Data = '0; bus.I_Index = '0; bus.I_Issue_No = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"}, 32'(bus.O_Count), 32'd0);
        check({tag, "_req"}, 32'(bus.O_Req), 32'd0);
        check({tag, "_stall"}, 32'(bus.O_Stall), 32'd0);
        check({tag, "_ovf"}, 32'(bus.O_Overflow), 32'd0);
        check({tag, "_data"}, bus.O_Data, 32'd0);
        check({tag, "_index"}, 32'(bus.O_Index), 32'd0);
        check({tag, "_issue"}, 32'(bus.O_Issue_No), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_en   = 1'b0;
        reset    = 1'b0;
        bus.I_Valid = 1'b0; bus.I_Grant = 1'b0; bus.I_Flush = 1'b0;
        bus.I_Data = '0; bus.I_Index = '0; bus.I_Issue_No = '0;
        #1;
        check_reset_vals("rst0");
        do_reset();
        chk_en = 1'b1;

        // Single push then single grant.
        tick(1, 32'h0000_00A5, 8'd3, 7'd5, 0, 0);
        check("single_req", 32'(bus.O_Req), 32'd1);
        check("single_data", bus.O_Data, 32'h0000_00A5);
        check("single_index", 32'(bus.O_Index), 32'd3);
        check("single_issue", 32'(bus.O_Issue_No), 32'd5);
        tick(0, '0, '0, '0, 1, 0);
        check("single_pop_req", 32'(bus.O_Req), 32'd0);
        check("single_pop_cnt", 32'(bus.O_Count), 32'd0);

        // Four pushes reach the stall threshold, then drain in order.
        for (int i = 0; i < 4; i++) tick(1, 32'(i * 7), 8'(i), 7'(10 + i), 0, 0);
        check("four_cnt", 32'(bus.O_Count), 32'd4);
        check("four_stall", 32'(bus.O_Stall), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("four_order", 32'(bus.O_Issue_No), 32'(10 + i));
            tick(0, '0, '0, '0, 1, 0);
            if (i == 0) begin
                check("four_cnt3", 32'(bus.O_Count), 32'd3);
                check("four_unstall", 32'(bus.O_Stall), 32'd0);
            end
        end

        // Full buffer: push with pop keeps count, push without pop overflows.
        for (int i = 0; i < 8; i++) tick(1, $urandom, 8'($urandom), 7'(20 + i), 0, 0);
        check("full_cnt", 32'(bus.O_Count), 32'd8);
        tick(1, 32'hCAFE_0028, 8'd28, 7'd28, 1, 0);
        check("full_pp_cnt", 32'(bus.O_Count), 32'd8);
        check("full_pp_ovf", 32'(bus.O_Overflow), 32'd0);
        check("full_pp_head", 32'(bus.O_Issue_No), 32'd21);
        tick(1, 32'hDEAD_0029, 8'd29, 7'd29, 0, 0);
        check("ovf_set", 32'(bus.O_Overflow), 32'd1);
        check("ovf_cnt", 32'(bus.O_Count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("ovf_no_drop", 32'(bus.O_Issue_No), 32'(21 + i));
            tick(0, '0, '0, '0, 1, 0);
        end
        check("ovf_sticky", 32'(bus.O_Overflow), 32'd1);

        // Flush beats a coincident push and pop.
        for (int i = 0; i < 5; i++) tick(1, $urandom, 8'($urandom), 7'(40 + i), 0, 0);
        check("pre_flush_cnt", 32'(bus.O_Count), 32'd5);
        tick(1, 32'h1234_5678, 8'd9, 7'd99, 1, 1);
        check("flush_cnt", 32'(bus.O_Count), 32'd0);
        check("flush_req", 32'(bus.O_Req), 32'd0);
        check("flush_stall", 32'(bus.O_Stall), 32'd0);
        check("flush_ovf_kept", 32'(bus.O_Overflow), 32'd1);

        // Streaming push+grant with pointer wrap; reset lands mid-stream.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1, 32'h100 + 32'(i), 8'(i), 7'(i), 1, 0);
            check("stream_cnt", 32'(bus.O_Count), 32'd1);
            check("stream_issue", 32'(bus.O_Issue_No), 32'(i));
            if (i == 12) begin
                reset = 1'b0;
                #1;
                check_reset_vals("midrst");
                break;
            end
        end
        bus.I_Valid = 1'b0; bus.I_Grant = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            tick(($urandom_range(99) < 60), $urandom, 8'($urandom), 7'($urandom),
                 ($urandom_range(99) < 50), ($urandom_range(99) < 2));
        end
        for (int c = 0; c < 12; c++) tick(0, '0, '0, '0, 1, 0);
        check("final_empty", 32'(bus.O_Count), 32'd0);

        @(negedge clock);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
